jpeg_bitstream_unpacker: RTL and testbench

- Entropy-decode front end of the JPEG decoder; the read-side counterpart of the encoder's bit packer and byte stuffer.
- Accepts the compressed scan as a byte stream and removes 0xFF/0x00 stuffing and 0xFF fill bytes.
- Detects markers and holds the scan at them until acknowledged.
- Presents an MSB-first bit window to the Huffman decoder, which consumes 1..16 bits per cycle.

---
 rtl/jpeg_bitstream_unpacker.sv | 130 +++++++++++++
 tb/tb_jpeg_bitstream_unpacker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_unpacker.sv
// rtl/jpeg_bitstream_unpacker.sv - JPEG scan byte unstuffer, marker detector and MSB-first bit window
// Bits are kept MSB-aligned in the buffer; everything below avail_cnt is held at zero.
module jpeg_bitstream_unpacker #(
  parameter int BUF_W  = 32,
  parameter int PEEK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PEEK_W-1:0] peek_bits,
  output logic [5:0]        avail_cnt,
  input  logic              consume_en,
  input  logic [4:0]        consume_len,
  output logic              err_underflow,
  output logic              marker_valid,
  output logic [7:0]        marker_code,
  input  logic              marker_ack
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SAW_FF = 2'd1,
    MARKER = 2'd2
  } state_t;

  localparam logic [5:0] FILL_LIMIT = 6'(BUF_W - 8);

  state_t           state;
  state_t           state_next;
  logic [BUF_W-1:0] buffer;

  logic             accept;
  logic             append_en;
  logic [7:0]       append_byte;
  logic             marker_set;
  logic             marker_clr;

  logic             consume_req;
  logic             underflow;
  logic [5:0]       shift_amt;
  logic [5:0]       surviving;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] placed;
  logic [BUF_W-1:0] buffer_next;
  logic [5:0]       avail_next;

  assign in_ready = (state != MARKER) && (avail_cnt <= FILL_LIMIT);
  assign accept   = in_valid && in_ready;

  // Underflow is judged against the pre-append count, so a same-cycle byte never rescues it.
  assign consume_req = consume_en && (consume_len != 5'd0);
  assign underflow   = consume_req && ({1'b0, consume_len} > avail_cnt);
  assign shift_amt   = (consume_req && !underflow) ? {1'b0, consume_len} : 6'd0;
  assign surviving   = avail_cnt - shift_amt;
  assign shifted     = buffer << shift_amt;
  assign placed      = {append_byte, {(BUF_W-8){1'b0}}} >> surviving;
  assign buffer_next = append_en ? (shifted | placed) : shifted;
  assign avail_next  = append_en ? (surviving + 6'd8) : surviving;

  assign peek_bits = buffer[BUF_W-1 -: PEEK_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    append_en   = 1'b0;
    append_byte = in_data;
    marker_set  = 1'b0;
    marker_clr  = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          if (in_data == 8'hFF) begin
            state_next = SAW_FF;
          end else begin
            append_en = 1'b1;
          end
        end
      end
      SAW_FF: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            append_en   = 1'b1;
            append_byte = 8'hFF;
            state_next  = RUN;
          end else if (in_data != 8'hFF) begin
            marker_set = 1'b1;
            state_next = MARKER;
          end
        end
      end
      MARKER: begin
        if (marker_ack) begin
          marker_clr = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer        <= '0;
      avail_cnt     <= 6'd0;
      err_underflow <= 1'b0;
      marker_valid  <= 1'b0;
      marker_code   <= 8'h00;
    end else begin
      buffer        <= buffer_next;
      avail_cnt     <= avail_next;
      err_underflow <= underflow;
      if (marker_set) begin
        marker_valid <= 1'b1;
        marker_code  <= in_data;
      end else if (marker_clr) begin
        marker_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// tb/tb_jpeg_bitstream_unpacker.sv - self-checking bench for jpeg_bitstream_unpacker
// A bit-queue model of the scan tracks the DUT every cycle; directed cases pin literal values.
module tb_jpeg_bitstream_unpacker;

  localparam int BUF_W  = 32;
  localparam int PEEK_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [PEEK_W-1:0] peek_bits;
  logic [5:0]        avail_cnt;
  logic              consume_en;
  logic [4:0]        consume_len;
  logic              err_underflow;
  logic              marker_valid;
  logic [7:0]        marker_code;
  logic              marker_ack;

  int checks = 0;
  int errors = 0;

  jpeg_bitstream_unpacker #(.BUF_W(BUF_W), .PEEK_W(PEEK_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .peek_bits(peek_bits), .avail_cnt(avail_cnt),
    .consume_en(consume_en), .consume_len(consume_len),
    .err_underflow(err_underflow),
    .marker_valid(marker_valid), .marker_code(marker_code), .marker_ack(marker_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the unstuffed scan as a queue of bits, oldest first.
  bit         mq[$];
  int         mst = 0;   // 0 data, 1 after 0xFF, 2 holding marker
  logic       mvalid = 1'b0;
  logic [7:0] mcode = 8'h00;
  logic       merr = 1'b0;
  logic       live = 1'b0;

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      mq.delete();
      mst = 0; mvalid = 1'b0; mcode = 8'h00; merr = 1'b0; live = 1'b1;
    end else begin
      acc  = in_valid && (mst != 2) && (mq.size() <= BUF_W - 8);
      merr = 1'b0;
      if (consume_en && consume_len != 0) begin
        if (int'(consume_len) > mq.size()) merr = 1'b1;
        else repeat (int'(consume_len)) void'(mq.pop_front());
      end
      if (mst == 2) begin
        if (marker_ack) begin mvalid = 1'b0; mst = 0; end
      end else if (acc) begin
        if (mst == 0) begin
          if (in_data == 8'hFF) mst = 1;
          else for (int i = 7; i >= 0; i--) mq.push_back(in_data[i]);
        end else begin
          if (in_data == 8'h00) begin
            for (int i = 0; i < 8; i++) mq.push_back(1'b1);
            mst = 0;
          end else if (in_data != 8'hFF) begin
            mcode = in_data; mvalid = 1'b1; mst = 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [PEEK_W-1:0] ep;
    if (live) begin
      ep = '0;
      for (int i = 0; i < PEEK_W; i++)
        if (i < mq.size()) ep[PEEK_W-1-i] = mq[i];
      chk("model peek_bits", int'(peek_bits), int'(ep));
      chk("model avail_cnt", int'(avail_cnt), mq.size());
      chk("model in_ready", int'(in_ready), int'((mst != 2) && (mq.size() <= BUF_W - 8)));
      chk("model err_underflow", int'(err_underflow), int'(merr));
      chk("model marker_valid", int'(marker_valid), int'(mvalid));
      chk("model marker_code", int'(marker_code), int'(mcode));
    end
  end

  task automatic idle();
    in_valid = 1'b0; in_data = 8'h00; consume_en = 1'b0;
    consume_len = 5'd0; marker_ack = 1'b0; rst = 1'b0;
  endtask

  // Drive one cycle of inputs, return at the following negedge.
  task automatic put(input logic [7:0] d, input logic v, input logic ce,
                     input logic [4:0] cl, input logic ack);
    in_data = d; in_valid = v; consume_en = ce; consume_len = cl; marker_ack = ack;
    @(posedge clk);
    #1 idle();
    @(negedge clk);
  endtask

  task automatic byte_in(input logic [7:0] d);
    put(d, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic eat(input logic [4:0] n);
    put(8'h00, 1'b0, 1'b1, n, 1'b0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset avail_cnt", int'(avail_cnt), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset marker_valid", int'(marker_valid), 0);
    chk("reset marker_code", int'(marker_code), 0);
    chk("reset err_underflow", int'(err_underflow), 0);

    byte_in(8'hA5); byte_in(8'h3C);
    chk("t1 avail", int'(avail_cnt), 16);
    chk("t1 peek", int'(peek_bits), 16'hA53C);
    eat(5'd4);
    chk("t1 avail after consume", int'(avail_cnt), 12);
    chk("t1 peek after consume", int'(peek_bits), 16'h53C0);
    eat(5'd12);

    byte_in(8'h12); byte_in(8'hFF); byte_in(8'h00); byte_in(8'h34);
    chk("t2 avail", int'(avail_cnt), 24);
    chk("t2 peek", int'(peek_bits), 16'h12FF);
    chk("t2 no marker", int'(marker_valid), 0);
    eat(5'd16);
    chk("t2 avail after consume", int'(avail_cnt), 8);
    chk("t2 peek after consume", int'(peek_bits), 16'h3400);
    eat(5'd8);

    byte_in(8'hA5); byte_in(8'hFF); byte_in(8'hFF); byte_in(8'hD9);
    chk("t3 marker_valid", int'(marker_valid), 1);
    chk("t3 marker_code", int'(marker_code), 8'hD9);
    chk("t3 in_ready held", int'(in_ready), 0);
    chk("t3 avail unchanged", int'(avail_cnt), 8);
    put(8'h00, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("t3 marker released", int'(marker_valid), 0);
    chk("t3 in_ready back", int'(in_ready), 1);
    eat(5'd8);

    byte_in(8'hA8); eat(5'd3);
    chk("t4 avail 5", int'(avail_cnt), 5);
    eat(5'd8);
    chk("t4 underflow pulse", int'(err_underflow), 1);
    chk("t4 avail kept", int'(avail_cnt), 5);
    chk("t4 peek kept", int'(peek_bits), 16'h4000);
    put(8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("t4 underflow one cycle", int'(err_underflow), 0);
    eat(5'd5);

    byte_in(8'hAB); byte_in(8'hCD); byte_in(8'hEF);
    put(8'h77, 1'b1, 1'b1, 5'd12, 1'b0);
    chk("t5 avail append+consume", int'(avail_cnt), 20);
    chk("t5 peek append+consume", int'(peek_bits), 16'hDEF7);
    eat(5'd16); eat(5'd4);
    byte_in(8'h01); byte_in(8'h02); byte_in(8'h03); byte_in(8'h04);
    chk("t5 full avail", int'(avail_cnt), 32);
    chk("t5 full in_ready", int'(in_ready), 0);
    byte_in(8'h55);
    chk("t5 refused byte", int'(avail_cnt), 32);
    eat(5'd4);
    chk("t5 28 in_ready", int'(in_ready), 0);
    eat(5'd4);
    chk("t5 24 in_ready", int'(in_ready), 1);
    eat(5'd16); eat(5'd8);

    byte_in(8'h12); byte_in(8'h34); byte_in(8'hFF);
    rst = 1'b1;
    put(8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("t6 avail after rst", int'(avail_cnt), 0);
    chk("t6 in_ready after rst", int'(in_ready), 1);
    chk("t6 marker after rst", int'(marker_valid), 0);
    byte_in(8'h00);
    chk("t6 zero is data", int'(avail_cnt), 8);
    chk("t6 still no marker", int'(marker_valid), 0);

    for (int n = 0; n < 4000; n++) begin
      int r;
      @(negedge clk);
      #1;
      r = $urandom_range(0, 15);
      in_data     = (r < 3) ? 8'hFF : (r == 3) ? 8'h00 : 8'($urandom);
      in_valid    = ($urandom_range(0, 3) != 0);
      consume_en  = ($urandom_range(0, 2) != 0);
      consume_len = 5'($urandom_range(0, 16));
      marker_ack  = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    #1 idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
